// File: rtl/bit_window_fetch_pkg.sv
// Shared widths and window-state encoding for the bit window feeder.
package bitwin_pkg;
  localparam int BYTE_W   = 8;
  localparam int WIN_W    = 16;
  localparam int MAX_TAKE = 8;

  typedef enum logic [1:0] {
    W_EMPTY = 2'd0,
    W_HALF  = 2'd1,
    W_FULL  = 2'd2
  } win_state_e;
endpackage

// File: rtl/bit_window_fetch_fifo.sv
// Small byte FIFO with registered storage, wrapping pointers and an occupancy count.
module byte_fifo
  import bitwin_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [BYTE_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [BYTE_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_wr = wr_en && !full && !clr;
  assign do_rd = rd_en && !empty && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/bit_window_fetch.sv
// Turns a valid/ready byte stream into a 16-bit LSB-first window plus bit offset for a funnel shifter.
module bit_window_fetch
  import bitwin_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BYTE_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIN_W-1:0]        win,
  output logic [3:0]              sh,
  output logic                    win_valid,
  input  logic                    take,
  input  logic [3:0]              take_len,
  output logic                    err,
  output logic [$clog2(DEPTH):0]  fifo_cnt
);
  win_state_e        state;
  win_state_e        state_nxt;
  logic [BYTE_W-1:0] lo;
  logic [BYTE_W-1:0] lo_nxt;
  logic [BYTE_W-1:0] hi;
  logic [BYTE_W-1:0] hi_nxt;
  logic [2:0]        off;
  logic [2:0]        off_nxt;
  logic              err_nxt;
  logic [4:0]        sum;
  logic              take_ok;
  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;

  // in_ready depends only on registered occupancy, never on take/take_len.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full && !flush;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign sum     = 5'(off) + 5'(take_len);
  assign take_ok = take && (state == W_FULL) && (take_len != 4'd0)
                   && (take_len <= 4'(MAX_TAKE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= W_EMPTY;
      lo    <= '0;
      hi    <= '0;
      off   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      lo    <= lo_nxt;
      hi    <= hi_nxt;
      off   <= off_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lo_nxt    = lo;
    hi_nxt    = hi;
    off_nxt   = off;
    err_nxt   = 1'b0;
    pop       = 1'b0;
    if (flush) begin
      state_nxt = W_EMPTY;
      lo_nxt    = '0;
      hi_nxt    = '0;
      off_nxt   = '0;
    end else if (take && !take_ok) begin
      // An illegal take freezes the window for this cycle and only raises err.
      err_nxt = 1'b1;
    end else begin
      case (state)
        W_EMPTY: begin
          if (!fifo_empty) begin
            lo_nxt    = head;
            pop       = 1'b1;
            state_nxt = W_HALF;
          end
        end
        W_HALF: begin
          if (!fifo_empty) begin
            hi_nxt    = head;
            pop       = 1'b1;
            state_nxt = W_FULL;
          end
        end
        W_FULL: begin
          if (take_ok) begin
            // sum is 1..15, so sum-8 on the wrap path is just its low three bits.
            off_nxt = sum[2:0];
            if (sum >= 5'd8) begin
              lo_nxt = hi;
              if (!fifo_empty) begin
                hi_nxt = head;
                pop    = 1'b1;
              end else begin
                hi_nxt    = '0;
                state_nxt = W_HALF;
              end
            end
          end
        end
        default: begin
          state_nxt = W_EMPTY;
          lo_nxt    = '0;
          hi_nxt    = '0;
          off_nxt   = '0;
        end
      endcase
    end
  end

  assign win       = {hi, lo};
  assign sh        = {1'b0, off};
  assign win_valid = (state == W_FULL);
endmodule

// File: tb/tb_bit_window_fetch.sv
// Directed plus randomized bench for bit_window_fetch against a byte-queue reference model.
module tb_bit_window_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] win;
  logic [3:0]  sh;
  logic        win_valid;
  logic        take;
  logic [3:0]  take_len;
  logic        err;
  logic [$clog2(DEPTH):0] fifo_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes waiting upstream, bytes in the window (oldest first), bit offset.
  logic [7:0] fq[$];
  logic [7:0] wq[$];
  int         m_off;
  logic       m_err;

  bit_window_fetch #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .win       (win),
    .sh        (sh),
    .win_valid (win_valid),
    .take      (take),
    .take_len  (take_len),
    .err       (err),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] funnel(input logic [15:0] w, input logic [3:0] n);
    logic [15:0] s;
    s = w >> n;
    return s[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    wq.delete();
    m_off = 0;
    m_err = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic [7:0] d, input logic t,
                              input logic [3:0] tl, input logic f);
    bit   accept;
    int   total;
    if (f) begin
      model_reset();
      return;
    end
    accept = v && (fq.size() < DEPTH);
    m_err  = 1'b0;
    if (t) begin
      if (wq.size() == 2 && tl >= 1 && tl <= 8) begin
        total = m_off + int'(tl);
        if (total >= 8) begin
          m_off = total - 8;
          void'(wq.pop_front());
          if (fq.size() > 0) wq.push_back(fq.pop_front());
        end else begin
          m_off = total;
        end
      end else begin
        m_err = 1'b1;
      end
    end else if (wq.size() < 2 && fq.size() > 0) begin
      wq.push_back(fq.pop_front());
    end
    if (accept) fq.push_back(d);
  endtask

  task automatic check_all(input string tag);
    logic [15:0] ew;
    ew = 16'h0000;
    if (wq.size() >= 1) ew[7:0]  = wq[0];
    if (wq.size() == 2) ew[15:8] = wq[1];
    chk({tag, ".win"},       32'(win),       32'(ew));
    chk({tag, ".sh"},        32'(sh),        32'(m_off));
    chk({tag, ".win_valid"}, 32'(win_valid), 32'(wq.size() == 2));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(fq.size() < DEPTH));
    chk({tag, ".fifo_cnt"},  32'(fifo_cnt),  32'(fq.size()));
    chk({tag, ".err"},       32'(err),       32'(m_err));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic t,
                      input logic [3:0] tl, input logic f, input string tag);
    in_valid = v;
    in_data  = d;
    take     = t;
    take_len = tl;
    flush    = f;
    @(posedge clk);
    model_update(v, d, t, tl, f);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, tag);
  endtask

  initial begin
    logic [15:0] win_save;
    logic [3:0]  sh_save;
    int          acc;

    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0;
    take = 1'b0; take_len = 4'd0;
    model_reset();
    #1;
    chk("rst.win", 32'(win), 32'h0);
    chk("rst.sh", 32'(sh), 32'h0);
    chk("rst.win_valid", 32'(win_valid), 32'h0);
    chk("rst.in_ready", 32'(in_ready), 32'h1);
    chk("rst.fifo_cnt", 32'(fifo_cnt), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill latency and first window.
    step(1'b1, 8'hA5, 1'b0, 4'd0, 1'b0, "fill0");
    step(1'b1, 8'h3C, 1'b0, 4'd0, 1'b0, "fill1");
    chk("fill1.not_yet", 32'(win_valid), 32'h0);
    idle("fill2");
    chk("fill.win_valid", 32'(win_valid), 32'h1);
    chk("fill.win", 32'(win), 32'h3CA5);
    chk("fill.b", 32'(funnel(win, sh)), 32'hA5);

    // Take without crossing a byte boundary.
    step(1'b0, 8'h00, 1'b1, 4'd3, 1'b0, "take3");
    chk("take3.sh", 32'(sh), 32'h3);
    chk("take3.b", 32'(funnel(win, sh)), 32'h94);
    chk("take3.win", 32'(win), 32'h3CA5);

    // Boundary crossing with and without a refill byte.
    step(1'b1, 8'h81, 1'b0, 4'd0, 1'b0, "push81");
    step(1'b0, 8'h00, 1'b1, 4'd7, 1'b0, "take7a");
    chk("take7a.win", 32'(win), 32'h813C);
    chk("take7a.sh", 32'(sh), 32'h2);
    chk("take7a.valid", 32'(win_valid), 32'h1);
    chk("take7a.cnt", 32'(fifo_cnt), 32'h0);
    step(1'b0, 8'h00, 1'b1, 4'd7, 1'b0, "take7b");
    chk("take7b.valid", 32'(win_valid), 32'h0);
    chk("take7b.win", 32'(win), 32'h0081);
    step(1'b1, 8'h5A, 1'b0, 4'd0, 1'b0, "refill0");
    chk("refill0.valid", 32'(win_valid), 32'h0);
    idle("refill1");
    chk("refill1.valid", 32'(win_valid), 32'h1);
    chk("refill1.win", 32'(win), 32'h5A81);

    // Back-pressure with no takes.
    step(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, "bp.flush");
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) acc++;
      step(1'b1, 8'(8'h10 + i), 1'b0, 4'd0, 1'b0, "bp.push");
    end
    chk("bp.accepted", 32'(acc), 32'd6);
    chk("bp.cnt", 32'(fifo_cnt), 32'd4);
    chk("bp.ready", 32'(in_ready), 32'h0);
    step(1'b0, 8'h00, 1'b1, 4'd8, 1'b0, "bp.take8");
    chk("bp.ready_back", 32'(in_ready), 32'h1);
    chk("bp.win", 32'(win), 32'h1211);

    // Illegal takes and flush priority.
    win_save = win;
    sh_save  = sh;
    step(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, "ill.len0");
    chk("ill.len0.err", 32'(err), 32'h1);
    chk("ill.len0.win", 32'(win), 32'(win_save));
    idle("ill.gap");
    chk("ill.pulse", 32'(err), 32'h0);
    step(1'b0, 8'h00, 1'b1, 4'd9, 1'b0, "ill.len9");
    chk("ill.len9.err", 32'(err), 32'h1);
    chk("ill.len9.sh", 32'(sh), 32'(sh_save));
    step(1'b0, 8'h00, 1'b0, 4'd0, 1'b1, "ill.flush");
    step(1'b0, 8'h00, 1'b1, 4'd4, 1'b0, "ill.invalid");
    chk("ill.invalid.err", 32'(err), 32'h1);
    step(1'b1, 8'h77, 1'b1, 4'd3, 1'b1, "flushall");
    chk("flushall.win", 32'(win), 32'h0);
    chk("flushall.cnt", 32'(fifo_cnt), 32'h0);
    chk("flushall.err", 32'(err), 32'h0);
    idle("flushall.after");
    chk("flushall.discard", 32'(fifo_cnt), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic       v, t, f;
      logic [7:0] d;
      logic [3:0] tl;
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      f  = ($urandom_range(0, 63) == 0);
      t  = ($urandom_range(0, 2) == 0);
      tl = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15))
                                         : 4'($urandom_range(1, 8));
      if ($urandom_range(0, 31) == 0) tl = 4'd0;
      step(v, d, t, tl, f, "rnd");
    end

    // Asynchronous reset mid-stream, then restart.
    step(1'b1, 8'hC3, 1'b0, 4'd0, 1'b0, "mid.push");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid.rst.win", 32'(win), 32'h0);
    chk("mid.rst.valid", 32'(win_valid), 32'h0);
    chk("mid.rst.ready", 32'(in_ready), 32'h1);
    chk("mid.rst.cnt", 32'(fifo_cnt), 32'h0);
    chk("mid.rst.sh", 32'(sh), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h4E, 1'b0, 4'd0, 1'b0, "post0");
    step(1'b1, 8'hD2, 1'b0, 4'd0, 1'b0, "post1");
    idle("post2");
    chk("post.win", 32'(win), 32'hD24E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
